muldiv_seq: RTL and testbench

- Parametrised sequential integer multiply/divide unit for the M1 CPU. It replaces the separate fixed 32-bit multiplier and divider with a single shared datapath.
- Handshake is Alternating Bit Protocol (ABP): a toggle on abp_req_i starts an operation; abp_ack_o is set equal to abp_req_i when the result is valid.
- Adds configurable width, multiply radix (bits per cycle), early termination, divide-by-zero detection and C-style signed remainder.

---
 rtl/muldiv_seq_pkg.sv | 19 +
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_mul_step.sv | 29 ++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation codes, FSM state encoding and a counter-width helper.
package muldiv_seq_pkg;

  localparam logic MULDIV_OP_MUL = 1'b0;
  localparam logic MULDIV_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE = 2'd0,
    MULDIV_ST_CALC = 2'd1,
    MULDIV_ST_FIX  = 2'd2
  } muldiv_state_e;

  // Bits needed to hold an iteration count of up to w.
  function automatic int unsigned muldiv_count_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Operand/result/handshake bundle of muldiv_seq. The requester drives the
// master side; the unit sits on the slave side.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             op_i;
  logic             signed_i;
  logic             abp_req_i;
  logic             abp_ack_o;
  logic [WIDTH-1:0] result_hi_o;
  logic [WIDTH-1:0] result_lo_o;
  logic             busy_o;
  logic             dbz_o;

  modport master (
    output a_i, b_i, op_i, signed_i, abp_req_i,
    input  abp_ack_o, result_hi_o, result_lo_o, busy_o, dbz_o
  );

  modport slave (
    input  a_i, b_i, op_i, signed_i, abp_req_i,
    output abp_ack_o, result_hi_o, result_lo_o, busy_o, dbz_o
  );
endinterface

// File: rtl/muldiv_mul_step.sv
// One multiply iteration: adds the MUL_BITS partial products selected by the
// low multiplier bits into the double-width accumulator.
module muldiv_mul_step #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic [2*WIDTH-1:0]  i_acc,
  input  logic [2*WIDTH-1:0]  i_mag_a,
  input  logic [MUL_BITS-1:0] i_mag_b_lo,
  output logic [2*WIDTH-1:0]  o_acc
);

  logic [2*WIDTH-1:0] w_pp [MUL_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign w_pp[gi] = i_mag_b_lo[gi] ? (i_mag_a << gi) : '0;
    end
  endgenerate

  always_comb begin
    o_acc = i_acc;
    for (int i = 0; i < MUL_BITS; i++) begin
      o_acc = o_acc + w_pp[i];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned multiply and restoring divide sharing one set of
// registers, started and completed through an alternating-bit handshake.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_BITS   = 1,
  parameter int EARLY_EXIT = 1
) (
  input logic          sys_clock_i,
  input logic          sys_reset_n_i,
  muldiv_seq_if.slave  bus
);

  localparam int CW = muldiv_count_w(WIDTH);
  localparam int W2 = 2 * WIDTH;

  muldiv_state_e    r_state;
  muldiv_state_e    w_state_next;
  logic             r_abp_last;
  logic             r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz_pend;
  logic [CW-1:0]    r_count;
  // MUL: r_mag_a = shifted multiplicand, r_mag_b = remaining multiplier, r_acc = product.
  // DIV: r_mag_a = shifted divisor, r_mag_b = quotient, r_acc = partial remainder.
  logic [W2-1:0]    r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic [W2-1:0]    r_acc;
  logic             r_ack;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic             w_start;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [W2-1:0]    w_mul_acc;
  logic [WIDTH-1:0] w_mag_b_shift;
  logic [W2:0]      w_diff;
  logic             w_calc_done;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_start    = (r_state == MULDIV_ST_IDLE) && (bus.abp_req_i != r_abp_last);
  assign w_div_zero = (bus.op_i == MULDIV_OP_DIV) && (bus.b_i == '0);
  assign w_abs_a    = (bus.signed_i && bus.a_i[WIDTH-1]) ? (~bus.a_i + 1'b1) : bus.a_i;
  assign w_abs_b    = (bus.signed_i && bus.b_i[WIDTH-1]) ? (~bus.b_i + 1'b1) : bus.b_i;

  muldiv_mul_step #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul_step (
    .i_acc      (r_acc),
    .i_mag_a    (r_mag_a),
    .i_mag_b_lo (r_mag_b[MUL_BITS-1:0]),
    .o_acc      (w_mul_acc)
  );

  assign w_mag_b_shift = r_mag_b >> MUL_BITS;
  assign w_diff        = {1'b0, r_acc} - {1'b0, r_mag_a};
  assign w_calc_done   = (r_count == CW'(1)) ||
                         ((r_op == MULDIV_OP_MUL) && (EARLY_EXIT != 0) && (w_mag_b_shift == '0));

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_mag_b + 1'b1) : r_mag_b;
  assign w_rem  = r_neg_r ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MULDIV_ST_IDLE: if (w_start) w_state_next = w_div_zero ? MULDIV_ST_FIX : MULDIV_ST_CALC;
      MULDIV_ST_CALC: if (w_calc_done) w_state_next = MULDIV_ST_FIX;
      MULDIV_ST_FIX:  w_state_next = MULDIV_ST_IDLE;
      default:        w_state_next = MULDIV_ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) begin
      r_state    <= MULDIV_ST_IDLE;
      r_abp_last <= 1'b0;
      r_op       <= MULDIV_OP_MUL;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_count    <= '0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_acc      <= '0;
      r_ack      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        MULDIV_ST_IDLE: begin
          if (w_start) begin
            r_abp_last <= bus.abp_req_i;
            r_op       <= bus.op_i;
            r_dbz_pend <= w_div_zero;
            r_neg_q    <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]) & ~w_div_zero;
            r_neg_r    <= bus.signed_i & bus.a_i[WIDTH-1] & ~w_div_zero;
            if (w_div_zero) begin
              // Divide by zero: all-ones quotient, dividend passed through as remainder.
              r_mag_b <= '1;
              r_acc   <= {{WIDTH{1'b0}}, bus.a_i};
            end else if (bus.op_i == MULDIV_OP_DIV) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_mag_a <= {1'b0, w_abs_b, {(WIDTH-1){1'b0}}};
              r_mag_b <= '0;
              r_count <= CW'(WIDTH);
            end else begin
              r_acc   <= '0;
              r_mag_a <= {{WIDTH{1'b0}}, w_abs_a};
              r_mag_b <= w_abs_b;
              r_count <= CW'(WIDTH / MUL_BITS);
            end
          end
        end
        MULDIV_ST_CALC: begin
          if (r_op == MULDIV_OP_MUL) begin
            r_acc   <= w_mul_acc;
            r_mag_a <= r_mag_a << MUL_BITS;
            r_mag_b <= w_mag_b_shift;
          end else begin
            if (!w_diff[W2]) r_acc <= w_diff[W2-1:0];
            r_mag_b <= {r_mag_b[WIDTH-2:0], ~w_diff[W2]};
            r_mag_a <= r_mag_a >> 1;
          end
          r_count <= r_count - 1'b1;
        end
        MULDIV_ST_FIX: begin
          r_ack <= r_abp_last;
          r_dbz <= r_dbz_pend;
          if (r_op == MULDIV_OP_MUL) begin
            r_hi <= w_prod[W2-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.abp_ack_o   = r_ack;
  assign bus.result_hi_o = r_hi;
  assign bus.result_lo_o = r_lo;
  assign bus.dbz_o       = r_dbz;
  assign bus.busy_o      = (r_state != MULDIV_ST_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a radix-2 instance without early exit and a
// radix-16 instance with early exit, driven through the handshake interface.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(32)) if0 ();
  muldiv_seq_if #(.WIDTH(32)) if1 ();

  muldiv_seq #(.WIDTH(32), .MUL_BITS(1), .EARLY_EXIT(0)) dut0 (
    .sys_clock_i   (clk),
    .sys_reset_n_i (rst_n),
    .bus           (if0)
  );

  muldiv_seq #(.WIDTH(32), .MUL_BITS(4), .EARLY_EXIT(1)) dut1 (
    .sys_clock_i   (clk),
    .sys_reset_n_i (rst_n),
    .bus           (if1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic read_out(input int d, output logic ack, output logic busy, output logic dbz,
                          output logic [31:0] hi, output logic [31:0] lo);
    if (d == 0) begin
      ack = if0.abp_ack_o; busy = if0.busy_o; dbz = if0.dbz_o;
      hi = if0.result_hi_o; lo = if0.result_lo_o;
    end else begin
      ack = if1.abp_ack_o; busy = if1.busy_o; dbz = if1.dbz_o;
      hi = if1.result_hi_o; lo = if1.result_lo_o;
    end
  endtask

  task automatic drive(input int d, input logic op, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, output logic lvl);
    @(negedge clk);
    if (d == 0) begin
      if0.op_i = op; if0.signed_i = sgn; if0.a_i = a; if0.b_i = b;
      if0.abp_req_i = ~if0.abp_req_i;
      lvl = if0.abp_req_i;
    end else begin
      if1.op_i = op; if1.signed_i = sgn; if1.a_i = a; if1.b_i = b;
      if1.abp_req_i = ~if1.abp_req_i;
      lvl = if1.abp_req_i;
    end
  endtask

  // n counts rising edges from the call up to and including the ack edge.
  task automatic wait_ack(input int d, input logic lvl, input string tag, output int n);
    logic ack, busy, dbz;
    logic [31:0] hi, lo;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      read_out(d, ack, busy, dbz, hi, lo);
      if (n == 1) check_val({tag, "_busy"}, {63'd0, busy}, 64'd1);
    end while (ack !== lvl && n < 200);
    if (ack !== lvl) check_val({tag, "_timeout"}, {63'd0, ack}, {63'd0, lvl});
    check_val({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input int d, input logic op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input int exp_lat, input string tag);
    logic lvl, ack, busy, dbz;
    logic [31:0] hi, lo;
    int n;
    drive(d, op, sgn, a, b, lvl);
    wait_ack(d, lvl, tag, n);
    read_out(d, ack, busy, dbz, hi, lo);
    $display("op %s dut%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
             tag, d, a, b, hi, lo, dbz, n - 1);
    check_val({tag, "_lat"}, 64'(n - 1), 64'(exp_lat));
    check_val({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check_val({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check_val({tag, "_dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
  endtask

  initial begin
    logic ack, busy, dbz, lvl1, lvl2;
    logic [31:0] hi, lo;
    int n;

    rst_n = 1'b0;
    if0.a_i = '0; if0.b_i = '0; if0.op_i = 1'b0; if0.signed_i = 1'b0; if0.abp_req_i = 1'b0;
    if1.a_i = '0; if1.b_i = '0; if1.op_i = 1'b0; if1.signed_i = 1'b0; if1.abp_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_out(0, ack, busy, dbz, hi, lo);
    check_val("rst_ack", {63'd0, ack}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_dbz", {63'd0, dbz}, 64'd0);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, MULDIV_OP_MUL, 1'b0, 32'd17, 32'd3, 32'd0, 32'd51, 1'b0, 33, "mul_u_17x3");
    run_op(1, MULDIV_OP_MUL, 1'b1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 2, "mul_s_m7x3_r4");
    run_op(0, MULDIV_OP_DIV, 1'b1, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, "div_s_m17d5");
    run_op(0, MULDIV_OP_DIV, 1'b0, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 33, "div_u_17d5");
    run_op(0, MULDIV_OP_DIV, 1'b1, 32'd17, 32'hFFFFFFFB, 32'd2, 32'hFFFFFFFD, 1'b0, 33, "div_s_17dm5");
    run_op(0, MULDIV_OP_DIV, 1'b0, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1, "div_by_zero");
    run_op(0, MULDIV_OP_MUL, 1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 33, "mul_after_dbz");
    run_op(0, MULDIV_OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, "div_min_m1");
    run_op(0, MULDIV_OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, 33, "mul_u_max");
    run_op(1, MULDIV_OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, 9, "mul_u_max_r4");
    run_op(1, MULDIV_OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 2, "mul_s_m1xm1_r4");
    run_op(1, MULDIV_OP_MUL, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 2, "mul_zero_r4");
    run_op(1, MULDIV_OP_MUL, 1'b1, 32'd3, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 2, "mul_s_3xm7_r4");
    run_op(1, MULDIV_OP_DIV, 1'b1, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, "div_s_m17d5_r4");

    // Reset ten cycles into a divide: the operation is dropped, no ack.
    drive(0, MULDIV_OP_DIV, 1'b0, 32'd1000, 32'd7, lvl1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    if0.abp_req_i = 1'b0;
    if1.abp_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_out(0, ack, busy, dbz, hi, lo);
    $display("op mid_reset dut0 -> ack=%0d busy=%0d hi=%h lo=%h dbz=%0d", ack, busy, hi, lo, dbz);
    check_val("mrst_ack", {63'd0, ack}, 64'd0);
    check_val("mrst_busy", {63'd0, busy}, 64'd0);
    check_val("mrst_hi", {32'd0, hi}, 64'd0);
    check_val("mrst_lo", {32'd0, lo}, 64'd0);
    check_val("mrst_dbz", {63'd0, dbz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, MULDIV_OP_MUL, 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 33, "post_rst_mul");

    // Second toggle while busy: picked up right after the first ack.
    drive(0, MULDIV_OP_DIV, 1'b0, 32'd17, 32'd5, lvl1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    if0.op_i = MULDIV_OP_MUL; if0.signed_i = 1'b0; if0.a_i = 32'd6; if0.b_i = 32'd7;
    if0.abp_req_i = ~if0.abp_req_i;
    lvl2 = if0.abp_req_i;
    wait_ack(0, lvl1, "defer1", n);
    read_out(0, ack, busy, dbz, hi, lo);
    $display("op defer1 dut0 -> hi=%h lo=%h dbz=%0d", hi, lo, dbz);
    check_val("defer1_hi", {32'd0, hi}, 64'd2);
    check_val("defer1_lo", {32'd0, lo}, 64'd3);
    wait_ack(0, lvl2, "defer2", n);
    read_out(0, ack, busy, dbz, hi, lo);
    $display("op defer2 dut0 -> hi=%h lo=%h dbz=%0d edges=%0d", hi, lo, dbz, n);
    check_val("defer2_edges", 64'(n), 64'd34);
    check_val("defer2_hi", {32'd0, hi}, 64'd0);
    check_val("defer2_lo", {32'd0, lo}, 64'd42);
    check_val("defer2_dbz", {63'd0, dbz}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
